// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with run/halt FSM and return-address stack
module pc_sequencer #(
   parameter int D           = 12,
   parameter int START_PC    = 0,
   parameter int STACK_DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         stall,
   input  logic         jump,
   input  logic         call,
   input  logic         ret,
   input  logic         halt,
   input  logic [3:0]   lut_sel,
   output logic [2:0]   lut_addr,
   output logic         lut_third,
   input  logic [D-1:0] lut_target,
   output logic [D-1:0] pc,
   output logic         running,
   output logic         done,
   output logic         stack_err
);

   localparam int AW = $clog2(STACK_DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] sp;
   logic [D-1:0]  stack [STACK_DEPTH];
   logic [D-1:0]  pc_inc;
   logic [AW-1:0] top_idx;
   logic          restart, advance, stack_empty, stack_full, push_en;

   assign lut_addr    = lut_sel[2:0];
   assign lut_third   = lut_sel[3];

   assign pc_inc      = pc + D'(1);
   assign top_idx     = sp[AW-1:0] - AW'(1);
   assign stack_empty = (sp == '0);
   assign stack_full  = (sp == PW'(STACK_DEPTH));
   assign restart     = start && (state != RUN);
   // advance: a RUN cycle in which Ret/Call/Jump/increment may act
   assign advance     = (state == RUN) && !stall && !halt;
   assign push_en     = advance && !ret && call && !stack_full;

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (!stall && halt) state_nxt = HALT;
         HALT:    if (start) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      running = (state == RUN);
      done    = (state == HALT);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc        <= '0;
         sp        <= '0;
         stack_err <= 1'b0;
      end else if (restart) begin
         pc        <= D'(START_PC);
         sp        <= '0;
         stack_err <= 1'b0;
      end else if (advance) begin
         if (ret) begin
            if (!stack_empty) begin
               pc <= stack[top_idx];
               sp <= sp - PW'(1);
            end else begin
               pc        <= pc_inc;
               stack_err <= 1'b1;
            end
         end else if (call) begin
            pc <= lut_target;
            if (!stack_full) sp <= sp + PW'(1);
            else             stack_err <= 1'b1;
         end else if (jump) begin
            pc <= lut_target;
         end else begin
            pc <= pc_inc;
         end
      end
   end

   // stack contents need no reset; only the pointer defines validity
   always_ff @(posedge clk) begin
      if (push_en) stack[sp[AW-1:0]] <= pc_inc;
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;

   typedef struct packed {
      logic [11:0] pc;
      logic        running;
      logic        done;
      logic        err;
   } obs_t;

   logic        clk = 1'b0;
   logic        reset, start, stall, jump, call, ret, halt;
   logic [3:0]  lut_sel;
   logic [2:0]  lut_addr;
   logic        lut_third;
   logic [11:0] lut_target;
   logic [11:0] pc;
   logic        running, done, stack_err;

   int checks   = 0;
   int failures = 0;

   obs_t sb[$];

   logic [11:0] m_pc;
   int          m_state;
   int          m_sp;
   logic [11:0] m_stack [4];
   logic        m_err;

   pc_sequencer #(.D(12), .START_PC(0), .STACK_DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stall      (stall),
      .jump       (jump),
      .call       (call),
      .ret        (ret),
      .halt       (halt),
      .lut_sel    (lut_sel),
      .lut_addr   (lut_addr),
      .lut_third  (lut_third),
      .lut_target (lut_target),
      .pc         (pc),
      .running    (running),
      .done       (done),
      .stack_err  (stack_err)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] lut_fn(input logic [3:0] s);
      case (s)
         4'd0:    return 12'd20;
         4'd1:    return 12'd60;
         4'd2:    return 12'd142;
         4'd3:    return 12'd185;
         4'd4:    return 12'd300;
         4'd5:    return 12'd512;
         4'd6:    return 12'd777;
         4'd7:    return 12'd4094;
         4'd8:    return 12'd399;
         4'd9:    return 12'd175;
         default: return 12'd0;
      endcase
   endfunction

   always_comb lut_target = lut_fn({lut_third, lut_addr});

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // drive one cycle of inputs, predict the post-edge state, compare after the edge
   task automatic step(input logic rst, input logic st, input logic sl, input logic j,
                       input logic c, input logic r, input logic h, input logic [3:0] sel);
      obs_t e, got;
      reset = rst; start = st; stall = sl; jump = j; call = c; ret = r; halt = h;
      lut_sel = sel;
      #1;
      chk("lut_passthru", {28'd0, lut_third, lut_addr}, {28'd0, sel});
      if (!rst) begin
         m_pc = 12'd0; m_state = 0; m_sp = 0; m_err = 1'b0;
      end else if (st && m_state != 1) begin
         m_pc = 12'd0; m_state = 1; m_sp = 0; m_err = 1'b0;
      end else if (m_state == 1 && !sl) begin
         if (h) m_state = 2;
         else if (r) begin
            if (m_sp > 0) begin
               m_sp = m_sp - 1;
               m_pc = m_stack[m_sp];
            end else begin
               m_pc = m_pc + 12'd1;
               m_err = 1'b1;
            end
         end else if (c) begin
            if (m_sp < 4) begin
               m_stack[m_sp] = m_pc + 12'd1;
               m_sp = m_sp + 1;
            end else m_err = 1'b1;
            m_pc = lut_fn(sel);
         end else if (j) m_pc = lut_fn(sel);
         else m_pc = m_pc + 12'd1;
      end
      e.pc = m_pc; e.running = (m_state == 1); e.done = (m_state == 2); e.err = m_err;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = '{pc: pc, running: running, done: done, err: stack_err};
      e = sb.pop_front();
      checks++;
      assert (got === e) else begin
         failures++;
         $error("FAIL step observed pc=%0d run=%0b done=%0b err=%0b expected pc=%0d run=%0b done=%0b err=%0b",
                got.pc, got.running, got.done, got.err, e.pc, e.running, e.done, e.err);
      end
      checks++;
      assert (!(running && done)) else begin
         failures++;
         $error("FAIL run_done_exclusive observed=%0b%0b expected=not both", running, done);
      end
   endtask

   task automatic idle_run(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 4'd0);
   endtask

   initial begin
      reset = 1'b0; start = 0; stall = 0; jump = 0; call = 0; ret = 0; halt = 0;
      lut_sel = 4'd0;
      m_pc = 12'd0; m_state = 0; m_sp = 0; m_err = 1'b0;
      @(posedge clk); #1;

      step(0, 0, 0, 0, 0, 0, 0, 4'd0);
      step(0, 0, 0, 0, 0, 0, 0, 4'd0);
      chk("reset_pc", {20'd0, pc}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      step(1, 0, 1, 1, 0, 0, 0, 4'd3);
      chk("idle_hold", {20'd0, pc}, 32'd0);

      step(1, 1, 0, 0, 0, 0, 0, 4'd0);
      chk("start_pc", {20'd0, pc}, 32'd0);
      chk("start_running", {31'd0, running}, 32'd1);
      idle_run(3);
      chk("count_3", {20'd0, pc}, 32'd3);
      idle_run(2);
      step(1, 0, 0, 1, 0, 0, 0, 4'b0011);
      chk("jump_sel3", {20'd0, pc}, 32'd185);
      step(1, 0, 0, 1, 0, 0, 0, 4'b1001);
      chk("jump_sel9", {20'd0, pc}, 32'd175);
      step(1, 1, 0, 0, 0, 0, 0, 4'd0);
      chk("start_in_run", {20'd0, pc}, 32'd176);

      step(1, 0, 0, 0, 0, 0, 1, 4'd0);
      step(1, 1, 0, 0, 0, 0, 0, 4'd0);
      idle_run(10);
      chk("pc_10", {20'd0, pc}, 32'd10);
      step(1, 0, 0, 0, 1, 0, 0, 4'd2);
      chk("call_target", {20'd0, pc}, 32'd142);
      idle_run(3);
      step(1, 0, 0, 0, 0, 1, 0, 4'd0);
      chk("ret_pc", {20'd0, pc}, 32'd11);
      chk("ret_err", {31'd0, stack_err}, 32'd0);

      step(1, 0, 0, 0, 1, 0, 0, 4'd0);
      step(1, 0, 0, 0, 1, 0, 0, 4'd1);
      step(1, 0, 0, 0, 1, 0, 0, 4'd4);
      step(1, 0, 0, 0, 1, 0, 0, 4'd5);
      chk("call4_no_err", {31'd0, stack_err}, 32'd0);
      step(1, 0, 0, 0, 1, 0, 0, 4'd6);
      chk("call5_branch", {20'd0, pc}, 32'd777);
      chk("call5_err", {31'd0, stack_err}, 32'd1);
      step(1, 0, 0, 0, 0, 1, 0, 4'd0);
      chk("ret1", {20'd0, pc}, 32'd301);
      step(1, 0, 0, 0, 0, 1, 0, 4'd0);
      step(1, 0, 0, 0, 0, 1, 0, 4'd0);
      step(1, 0, 0, 0, 0, 1, 0, 4'd0);
      chk("ret4", {20'd0, pc}, 32'd12);
      step(1, 0, 0, 0, 0, 1, 0, 4'd0);
      chk("ret5_inc", {20'd0, pc}, 32'd13);
      chk("ret5_err", {31'd0, stack_err}, 32'd1);

      step(1, 0, 0, 1, 0, 0, 0, 4'd7);
      idle_run(1);
      chk("pc_4095", {20'd0, pc}, 32'd4095);
      idle_run(1);
      chk("wrap_0", {20'd0, pc}, 32'd0);
      step(1, 0, 1, 1, 0, 0, 0, 4'd3);
      chk("stall_jump", {20'd0, pc}, 32'd0);
      step(1, 0, 1, 0, 0, 0, 1, 4'd0);
      idle_run(1);
      chk("stall_resume", {20'd0, pc}, 32'd1);
      step(1, 0, 0, 1, 0, 0, 0, 4'd12);
      chk("lut_high_sel", {20'd0, pc}, 32'd0);

      step(1, 0, 0, 1, 0, 0, 0, 4'd8);
      idle_run(1);
      step(1, 0, 0, 0, 0, 0, 1, 4'd0);
      chk("halt_pc", {20'd0, pc}, 32'd400);
      chk("halt_done", {31'd0, done}, 32'd1);
      step(1, 0, 0, 1, 1, 0, 0, 4'd3);
      chk("halt_hold", {20'd0, pc}, 32'd400);
      step(1, 1, 0, 0, 0, 0, 0, 4'd0);
      chk("restart_pc", {20'd0, pc}, 32'd0);
      idle_run(2);
      step(0, 0, 0, 0, 0, 0, 0, 4'd0);
      chk("midrun_reset_pc", {20'd0, pc}, 32'd0);
      chk("midrun_reset_run", {31'd0, running}, 32'd0);
      step(1, 0, 0, 1, 0, 0, 0, 4'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
